// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg: pipeline defines shared by ID, EX and ME (bus widths, ID->EX bus layout, ALU op bits, divider states)
package ex_unit_pkg;
    localparam int ID_EX_W  = 152;
    localparam int EX_ME_W  = 71;
    localparam int EX_FWD_W = 38;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic        div_en;
        logic        div_signed;
        logic        div_rem;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [31:0] rkd_value;
        logic        mem_en;
        logic        mem_we;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } id_ex_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/div_unit.sv
// div_unit: 32-iteration radix-2 restoring divider, signed or unsigned
//   start/signed_op/dividend/divisor : request, sampled in IDLE
//   ack                              : result consumed, DONE -> IDLE
//   busy/done/quotient/remainder     : status and results (valid while done)
module div_unit
    import ex_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    div_state_t  state, state_n;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs, abs_a, abs_b;
    logic        neg_q, neg_r, dz;
    logic [32:0] shifted;
    logic [33:0] diff;

    // work on magnitudes, fix signs at the output
    assign abs_a   = signed_op && dividend[31] ? -dividend : dividend;
    assign abs_b   = signed_op && divisor[31] ? -divisor : divisor;
    assign shifted = {rem, quo[31]};
    assign diff    = {1'b0, shifted} - {2'b0, dvs};

    always_comb begin
        state_n = state;
        state_n = (state == DIV_IDLE && start) ? DIV_BUSY :
                  (state == DIV_BUSY && cnt == 5'd31) ? DIV_DONE :
                  (state == DIV_DONE && ack) ? DIV_IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_n;
            if (state == DIV_IDLE && start) begin
                quo   <= abs_a;
                dvs   <= abs_b;
                rem   <= 32'd0;
                neg_q <= signed_op && (dividend[31] ^ divisor[31]);
                neg_r <= signed_op && dividend[31];
                dz    <= divisor == 32'd0;
                cnt   <= 5'd0;
            end else if (state == DIV_BUSY) begin
                quo <= {quo[30:0], !diff[33]};
                rem <= diff[33] ? shifted[31:0] : diff[31:0];
                cnt <= cnt + 5'd1;
            end
        end
    end

    // divide by zero yields all-ones quotient; remainder already equals dividend after sign fix
    assign busy      = state == DIV_BUSY;
    assign done      = state == DIV_DONE;
    assign quotient  = dz ? 32'hFFFF_FFFF : neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;
endmodule

// File: rtl/ex_unit.sv
// ex_unit: pipeline execute stage (inline ALU, multi-cycle divider, data SRAM request)
//   ID_to_EX_Valid/ID_to_EX_Bus/EX_Allow_in : ID handshake
//   EX_to_ME_Valid/EX_to_ME_Bus/ME_Allow_in : ME handshake
//   data_sram_*                             : data SRAM request
//   EX_dest/EX_Forward                      : hazard/forwarding info to ID
module ex_unit
    import ex_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ID_to_EX_Valid,
    input  logic [ID_EX_W-1:0]  ID_to_EX_Bus,
    output logic                EX_Allow_in,
    input  logic                ME_Allow_in,
    output logic                EX_to_ME_Valid,
    output logic [EX_ME_W-1:0]  EX_to_ME_Bus,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    output logic [4:0]          EX_dest,
    output logic [EX_FWD_W-1:0] EX_Forward
);
    id_ex_t      ex_q;
    logic        ex_valid, ready_go;
    logic        div_busy, div_done;
    logic [31:0] a, b, alu_res, quo, rem, result;
    logic [11:0] op;

    assign ready_go       = !ex_q.div_en || div_done;
    assign EX_Allow_in    = !ex_valid || (ready_go && ME_Allow_in);
    assign EX_to_ME_Valid = ex_valid && ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else begin
            if (EX_Allow_in)
                ex_valid <= ID_to_EX_Valid;
            if (ID_to_EX_Valid && EX_Allow_in)
                ex_q <= id_ex_t'(ID_to_EX_Bus);
        end
    end

    assign a  = ex_q.alu_src1;
    assign b  = ex_q.alu_src2;
    assign op = ex_q.alu_op;

    assign alu_res = op[ALU_ADD]  ? a + b :
                     op[ALU_SUB]  ? a - b :
                     op[ALU_SLT]  ? {31'd0, $signed(a) < $signed(b)} :
                     op[ALU_SLTU] ? {31'd0, a < b} :
                     op[ALU_AND]  ? a & b :
                     op[ALU_NOR]  ? ~(a | b) :
                     op[ALU_OR]   ? a | b :
                     op[ALU_XOR]  ? a ^ b :
                     op[ALU_SLL]  ? a << b[4:0] :
                     op[ALU_SRL]  ? a >> b[4:0] :
                     op[ALU_SRA]  ? $unsigned($signed(a) >>> b[4:0]) :
                     op[ALU_LUI]  ? b : 32'd0;

    div_unit u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (ex_valid && ex_q.div_en && !div_busy && !div_done),
        .ack       (EX_to_ME_Valid && ME_Allow_in),
        .signed_op (ex_q.div_signed),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    assign result = ex_q.div_en ? (ex_q.div_rem ? rem : quo) : alu_res;

    // request only when ME takes the instruction this cycle, so a stall never issues it twice
    assign data_sram_en    = ex_valid && ex_q.mem_en && ready_go && ME_Allow_in;
    assign data_sram_we    = {4{ex_q.mem_we && data_sram_en}};
    assign data_sram_addr  = result;
    assign data_sram_wdata = ex_q.rkd_value;

    assign EX_to_ME_Bus = {ex_q.pc, result, ex_q.res_from_mem, ex_q.gr_we, ex_q.dest};
    assign EX_dest      = ex_valid ? ex_q.dest : 5'd0;
    assign EX_Forward   = {EX_dest, ex_q.res_from_mem && ex_valid, result};
endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: directed self-checking bench for ex_unit
module tb_ex_unit;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ID_to_EX_Valid = 1'b0;
    logic [151:0] ID_to_EX_Bus = '0;
    logic         EX_Allow_in;
    logic         ME_Allow_in = 1'b1;
    logic         EX_to_ME_Valid;
    logic [70:0]  EX_to_ME_Bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   EX_dest;
    logic [37:0]  EX_Forward;

    int checks = 0;
    int failures = 0;

    ex_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_EX_Valid  (ID_to_EX_Valid),
        .ID_to_EX_Bus    (ID_to_EX_Bus),
        .EX_Allow_in     (EX_Allow_in),
        .ME_Allow_in     (ME_Allow_in),
        .EX_to_ME_Valid  (EX_to_ME_Valid),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .EX_dest         (EX_dest),
        .EX_Forward      (EX_Forward)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [151:0] mk(input logic [31:0] pc, input logic [11:0] op,
                                        input logic de, input logic ds, input logic dr,
                                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd,
                                        input logic me, input logic mw, input logic rfm, input logic gw,
                                        input logic [4:0] d);
        return {pc, op, de, ds, dr, s1, s2, rkd, me, mw, rfm, gw, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [151:0] b);
        ID_to_EX_Valid = 1'b1;
        ID_to_EX_Bus = b;
        tick();
        ID_to_EX_Valid = 1'b0;
    endtask

    task automatic run_div(input logic [151:0] b, output int lat, output logic [31:0] res, output logic allow_seen);
        send(b);
        lat = 0;
        allow_seen = 1'b0;
        while (!EX_to_ME_Valid && lat < 100) begin
            if (EX_Allow_in) allow_seen = 1'b1;
            tick();
            lat++;
        end
        res = EX_to_ME_Bus[38:7];
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (EX_to_ME_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", EX_to_ME_Valid); end
        checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL reset_sram_en got %b exp 0", data_sram_en); end
        checks++; if (data_sram_we !== 4'h0) begin failures++; $display("FAIL reset_sram_we got %h exp 0", data_sram_we); end
        checks++; if (EX_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got %0d exp 0", EX_dest); end
        checks++; if (EX_Allow_in !== 1'b1) begin failures++; $display("FAIL reset_allow got %b exp 1", EX_Allow_in); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        ME_Allow_in = 1'b1;
        send(mk(32'h100, 12'h001, 0, 0, 0, 32'd5, 32'd7, 32'd0, 0, 0, 0, 1, 5'd3));
        checks++; if (EX_to_ME_Valid !== 1'b1) begin failures++; $display("FAIL add_valid got %b exp 1", EX_to_ME_Valid); end
        checks++; if (EX_to_ME_Bus !== {32'h100, 32'd12, 1'b0, 1'b1, 5'd3}) begin failures++; $display("FAIL add_bus got %h exp %h", EX_to_ME_Bus, {32'h100, 32'd12, 1'b0, 1'b1, 5'd3}); end
        checks++; if (EX_Allow_in !== 1'b1) begin failures++; $display("FAIL add_allow got %b exp 1", EX_Allow_in); end
        checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL add_sram_en got %b exp 0", data_sram_en); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [0:11];
        logic [31:0] vb [0:11];
        logic [31:0] ve [0:11];
        va = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0F0F_F0F0, 32'h0F0F_0000,
               32'h0F00_0000, 32'hFFFF_0000, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_0000};
        vb = '{32'd2, 32'd7, 32'd1, 32'd1, 32'h00FF_FF00, 32'h0000_00F0,
               32'h0000_00F0, 32'h0FF0_0FF0, 32'h0000_003F, 32'd4, 32'h0000_0024, 32'h1234_5000};
        ve = '{32'd1, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h000F_F000, 32'hF0F0_FF0F,
               32'h0F00_00F0, 32'hF00F_0FF0, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h1234_5000};
        ME_Allow_in = 1'b1;
        ID_to_EX_Valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ID_to_EX_Bus = mk(32'h200 + i * 4, 12'h001 << i, 0, 0, 0, va[i], vb[i], 32'd0, 0, 0, 0, 1, 5'(i + 1));
            tick();
            checks++;
            if (EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus[38:7] !== ve[i] || EX_dest !== 5'(i + 1))
            begin failures++; $display("FAIL alu_op%0d got v=%b res=%h dest=%0d exp v=1 res=%h dest=%0d", i, EX_to_ME_Valid, EX_to_ME_Bus[38:7], EX_dest, ve[i], i + 1); end
        end
        ID_to_EX_Valid = 1'b0;
        tick();
    endtask

    task automatic test_div_signed();
        int lat;
        logic [31:0] res;
        logic allow_seen;
        run_div(mk(32'h300, 12'h000, 1, 1, 0, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 0, 0, 1, 5'd4), lat, res, allow_seen);
        checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got %0d exp 33", lat); end
        checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_signed_quo got %h exp fffffffd", res); end
        checks++; if (allow_seen !== 1'b0) begin failures++; $display("FAIL div_allow_in got %b exp 0", allow_seen); end
        run_div(mk(32'h304, 12'h000, 1, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 0, 0, 1, 5'd4), lat, res, allow_seen);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_signed_rem got %h exp ffffffff", res); end
        run_div(mk(32'h308, 12'h000, 1, 0, 0, 32'd100, 32'd7, 32'd0, 0, 0, 0, 1, 5'd4), lat, res, allow_seen);
        checks++; if (res !== 32'd14) begin failures++; $display("FAIL div_unsigned_quo got %h exp 0000000e", res); end
    endtask

    task automatic test_div_edge();
        int lat;
        logic [31:0] res;
        logic allow_seen;
        run_div(mk(32'h400, 12'h000, 1, 0, 0, 32'd100, 32'd0, 32'd0, 0, 0, 0, 1, 5'd5), lat, res, allow_seen);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_quo got %h exp ffffffff", res); end
        run_div(mk(32'h404, 12'h000, 1, 0, 1, 32'd100, 32'd0, 32'd0, 0, 0, 0, 1, 5'd5), lat, res, allow_seen);
        checks++; if (res !== 32'd100) begin failures++; $display("FAIL divz_rem got %h exp 00000064", res); end
        run_div(mk(32'h408, 12'h000, 1, 1, 0, 32'hFFFF_FFF9, 32'd0, 32'd0, 0, 0, 0, 1, 5'd5), lat, res, allow_seen);
        checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_signed_quo got %h exp ffffffff", res); end
        run_div(mk(32'h40C, 12'h000, 1, 1, 1, 32'hFFFF_FFF9, 32'd0, 32'd0, 0, 0, 0, 1, 5'd5), lat, res, allow_seen);
        checks++; if (res !== 32'hFFFF_FFF9) begin failures++; $display("FAIL divz_signed_rem got %h exp fffffff9", res); end
        run_div(mk(32'h410, 12'h000, 1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1, 5'd5), lat, res, allow_seen);
        checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL ovf_quo got %h exp 80000000", res); end
        run_div(mk(32'h414, 12'h000, 1, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1, 5'd5), lat, res, allow_seen);
        checks++; if (res !== 32'd0) begin failures++; $display("FAIL ovf_rem got %h exp 00000000", res); end
    endtask

    task automatic test_store_stall();
        logic [70:0] exp_bus;
        exp_bus = {32'h500, 32'h0000_1000, 1'b0, 1'b0, 5'd0};
        ME_Allow_in = 1'b0;
        send(mk(32'h500, 12'h001, 0, 0, 0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1, 1, 0, 0, 5'd0));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_sram_en !== 1'b0 || EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus !== exp_bus || EX_Allow_in !== 1'b0)
            begin failures++; $display("FAIL store_stall%0d got en=%b v=%b allow=%b bus=%h exp en=0 v=1 allow=0 bus=%h", i, data_sram_en, EX_to_ME_Valid, EX_Allow_in, EX_to_ME_Bus, exp_bus); end
            tick();
        end
        ME_Allow_in = 1'b1;
        #1;
        checks++;
        if (data_sram_en !== 1'b1 || data_sram_we !== 4'hF || data_sram_addr !== 32'h1000 || data_sram_wdata !== 32'hDEAD_BEEF)
        begin failures++; $display("FAIL store_issue got en=%b we=%h addr=%h wdata=%h exp en=1 we=f addr=00001000 wdata=deadbeef", data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata); end
        tick();
        checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0) begin failures++; $display("FAIL store_once got en=%b we=%h exp en=0 we=0", data_sram_en, data_sram_we); end
    endtask

    task automatic test_reset_busy();
        int lat;
        logic [31:0] res;
        logic allow_seen;
        ME_Allow_in = 1'b1;
        send(mk(32'h600, 12'h000, 1, 0, 0, 32'd100, 32'd3, 32'd0, 1, 1, 0, 1, 5'd7));
        for (int i = 0; i < 11; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (EX_to_ME_Valid !== 1'b0 || EX_Allow_in !== 1'b1 || EX_dest !== 5'd0 || data_sram_en !== 1'b0)
        begin failures++; $display("FAIL reset_busy got v=%b allow=%b dest=%0d en=%b exp v=0 allow=1 dest=0 en=0", EX_to_ME_Valid, EX_Allow_in, EX_dest, data_sram_en); end
        send(mk(32'h604, 12'h001, 0, 0, 0, 32'd1, 32'd2, 32'd0, 0, 0, 0, 1, 5'd8));
        checks++;
        if (EX_to_ME_Valid !== 1'b1 || EX_to_ME_Bus[38:7] !== 32'd3)
        begin failures++; $display("FAIL reset_busy_add got v=%b res=%h exp v=1 res=00000003", EX_to_ME_Valid, EX_to_ME_Bus[38:7]); end
        tick();
        run_div(mk(32'h608, 12'h000, 1, 0, 0, 32'd100, 32'd3, 32'd0, 0, 0, 0, 1, 5'd9), lat, res, allow_seen);
        checks++;
        if (lat !== 33 || res !== 32'd33)
        begin failures++; $display("FAIL reset_busy_div got lat=%0d res=%h exp lat=33 res=00000021", lat, res); end
    endtask

    task automatic test_forward();
        ME_Allow_in = 1'b1;
        send(mk(32'h700, 12'h001, 0, 0, 0, 32'h0000_2000, 32'd4, 32'd0, 1, 0, 1, 1, 5'd9));
        checks++;
        if (EX_Forward !== {5'd9, 1'b1, 32'h0000_2004} || EX_dest !== 5'd9)
        begin failures++; $display("FAIL fwd_load got fwd=%h dest=%0d exp fwd=%h dest=9", EX_Forward, EX_dest, {5'd9, 1'b1, 32'h0000_2004}); end
        checks++;
        if (data_sram_en !== 1'b1 || data_sram_we !== 4'h0 || data_sram_addr !== 32'h2004)
        begin failures++; $display("FAIL load_req got en=%b we=%h addr=%h exp en=1 we=0 addr=00002004", data_sram_en, data_sram_we, data_sram_addr); end
        tick();
        checks++;
        if (EX_dest !== 5'd0 || EX_Forward[32] !== 1'b0 || EX_Forward[37:33] !== 5'd0)
        begin failures++; $display("FAIL fwd_idle got dest=%0d fwd_hi=%h exp dest=0 fwd_hi=00", EX_dest, EX_Forward[37:32]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_div_signed();
        test_div_edge();
        test_store_stall();
        test_reset_busy();
        test_forward();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ID_to_EX_Valid  input  1  upstream (ID) has a valid instruction on ID_to_EX_Bus.
REQ-004 ID_to_EX_Bus  input  152  pc[151:120], alu_op[119:108], div_en[107], div_signed[106], div_rem[105], alu_src1[104:73], alu_src2[72:41], rkd_value[40:9], mem_en[8], mem_we[7], res_from_mem[6], gr_we[5], dest[4:0].
REQ-005 EX_Allow_in  output  1  EX can accept from ID this cycle.
REQ-006 ME_Allow_in  input  1  ME stage can accept this cycle.
REQ-007 EX_to_ME_Valid  output  1  EX presents a completed instruction.
REQ-008 EX_to_ME_Bus  output  71  pc[70:39], result[38:7], res_from_mem[6], gr_we[5], dest[4:0].
REQ-009 data_sram_en / data_sram_we / data_sram_addr / data_sram_wdata  output  1/4/32/32  data SRAM request; read data returns to ME next cycle.
REQ-010 EX_dest  output  5  dest masked to 0 when EX_Valid=0.
REQ-011 EX_Forward  output  38  {EX_dest, res_from_mem & EX_Valid, result}; res_from_mem bit flags load-use hazard to ID.

Function
REQ-012 Handshake: EX_Allow_in = !EX_Valid || (EX_ReadyGO && ME_Allow_in); EX_to_ME_Valid = EX_Valid && EX_ReadyGO.
REQ-013 EX_Valid SHALL load ID_to_EX_Valid when EX_Allow_in; bus fields SHALL latch only when ID_to_EX_Valid && EX_Allow_in.
REQ-014 alu_op one-hot, bit0..11: add, sub, slt(signed), sltu, and, nor, or, xor, sll, srl, sra, lui(result=src2); shift amount = src2[4:0]; all arithmetic mod 2^32.
REQ-015 div_en=0: result = ALU output, EX_ReadyGO=1, zero extra latency.
REQ-016 div_en=1: result = quotient (div_rem=0) or remainder (div_rem=1); div_signed selects signed (truncate toward zero, remainder sign follows dividend) or unsigned.
REQ-017 Divider FSM states IDLE, BUSY, DONE: IDLE->BUSY on first cycle EX_Valid&&div_en; BUSY runs 32 radix-2 restoring iterations (5-bit counter 0..31) then ->DONE; DONE->IDLE when EX_to_ME_Valid && ME_Allow_in.
REQ-018 Div latency: instruction latched at edge N -> EX_ReadyGO high in cycle N+33 (first cycle in DONE); held until ME accepts.
REQ-019 Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend; no exception.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-021 data_sram_en = EX_Valid && mem_en && EX_ReadyGO && ME_Allow_in; issued exactly once per instruction, never during ME stall.
REQ-022 data_sram_we = {4{mem_we && data_sram_en}}; addr = result; wdata = rkd_value.
REQ-023 ME stall (ME_Allow_in=0) with EX_to_ME_Valid=1: all EX outputs and EX_to_ME_Bus SHALL hold stable.

Reset
REQ-024 reset SHALL clear EX_Valid and FSM to IDLE, counter 0; outputs: EX_to_ME_Valid=0, data_sram_en=0, data_sram_we=0, EX_dest=0, EX_Allow_in=1.
REQ-025 reset during BUSY SHALL abort division; no SRAM request issued for aborted instruction.

Structure
REQ-026 Bus widths (152, 71, 38) and alu_op bit indices SHALL live in a shared pipeline-defines package used by ID, EX, ME.
REQ-027 Divider SHALL be sub-module div_unit (start, signed, dividend, divisor -> busy, done, quotient, remainder); ALU stays inline.

Verification
REQ-028 add src1=5 src2=7, ME_Allow_in=1 -> next cycle EX_to_ME_Bus result=12, EX_to_ME_Valid=1, no stall.
REQ-029 signed div 0xFFFFFFF9/2 -> quotient 0xFFFFFFFD, rem 0xFFFFFFFF, EX_ReadyGO first high 33 cycles after latch; EX_Allow_in=0 meanwhile.
REQ-030 unsigned div 100/0 -> quotient 0xFFFFFFFF; div_rem variant -> 100.
REQ-031 store addr 0x1000 wdata 0xDEADBEEF with ME_Allow_in=0 for 3 cycles -> data_sram_en low for 3 cycles, then exactly one pulse we=0xF.
REQ-032 reset asserted at BUSY iteration 10 -> next cycle EX_Valid=0, FSM IDLE; following add completes with zero-stall latency.
REQ-033 load in EX -> EX_Forward[32]=1, EX_dest=dest; EX_Valid=0 -> EX_dest=0.
